// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM dead-time block.
// Optional trip handling is compiled in with PWM_DT_FAULT_EN.
package pwm_pkg;

    localparam int unsigned DT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LOW   = 3'd1,
        ST_DT_R  = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DT_F  = 3'd4
`ifdef PWM_DT_FAULT_EN
        ,
        ST_FAULT = 3'd5
`endif
    } pwm_state_e;

endpackage

// File: rtl/pwm_dt_counter.sv
// Dead-time down-counter: loads on request, counts down to zero, flags the last cycle.
module pwm_dt_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load takes priority; otherwise decrement and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A count of one means this is the final dead cycle.
    assign expire_c = (count_q == W'(1));

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with programmable dead time.
// Define PWM_DT_FAULT_EN to add a latched trip state driven by fault/fault_clr.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pwm_in,
    input  logic            en,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            fault_flag
);

    pwm_state_e      state_q, state_d;
    logic            pwm_q;
    logic            pwm_h_q, pwm_h_d;
    logic            pwm_l_q, pwm_l_d;
    logic            load_c;
    logic [DT_W-1:0] load_val_c;
    logic            expire_c;
    logic [DT_W-1:0] dt_rise_eff_c;
    logic [DT_W-1:0] dt_fall_eff_c;

    // A programmed dead time of zero still yields one dead cycle.
    assign dt_rise_eff_c = (dt_rise == '0) ? DT_W'(1) : dt_rise;
    assign dt_fall_eff_c = (dt_fall == '0) ? DT_W'(1) : dt_fall;

    pwm_dt_counter #(
        .W (DT_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (load_c),
        .load_val (load_val_c),
        .expire_c (expire_c)
    );

    // Next-state, counter load and output decode from the next state.
    always_comb begin
        state_d    = state_q;
        load_c     = 1'b0;
        load_val_c = dt_rise_eff_c;
        case (state_q)
            ST_OFF: begin
                if (en) state_d = ST_LOW;
            end
            ST_LOW: begin
                if (!en) begin
                    state_d = ST_OFF;
                end else if (pwm_q) begin
                    state_d    = ST_DT_R;
                    load_c     = 1'b1;
                    load_val_c = dt_rise_eff_c;
                end
            end
            ST_DT_R: begin
                if (!en)           state_d = ST_OFF;
                else if (!pwm_q)   state_d = ST_LOW;
                else if (expire_c) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (!en) begin
                    state_d = ST_OFF;
                end else if (!pwm_q) begin
                    state_d    = ST_DT_F;
                    load_c     = 1'b1;
                    load_val_c = dt_fall_eff_c;
                end
            end
            ST_DT_F: begin
                if (!en)           state_d = ST_OFF;
                else if (pwm_q)    state_d = ST_HIGH;
                else if (expire_c) state_d = ST_LOW;
            end
`ifdef PWM_DT_FAULT_EN
            ST_FAULT: begin
                if (fault_clr && !fault) state_d = ST_OFF;
            end
`endif
            default: state_d = ST_OFF;
        endcase
`ifdef PWM_DT_FAULT_EN
        // A trip overrides every other transition, including a clear.
        if (fault) begin
            state_d = ST_FAULT;
            load_c  = 1'b0;
        end
`endif
        pwm_h_d = (state_d == ST_HIGH);
        pwm_l_d = (state_d == ST_LOW);
    end

    // State, input sample and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_OFF;
            pwm_q   <= 1'b0;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pwm_q   <= pwm_in;
            pwm_h_q <= pwm_h_d;
            pwm_l_q <= pwm_l_d;
        end
    end

    assign pwm_h = pwm_h_q;
    assign pwm_l = pwm_l_q;

`ifdef PWM_DT_FAULT_EN
    logic fault_flag_q;

    // Trip indicator follows residence in the fault state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_flag_q <= 1'b0;
        end else begin
            fault_flag_q <= (state_d == ST_FAULT);
        end
    end

    assign fault_flag = fault_flag_q;
`else
    logic unused_fault_c;
    assign unused_fault_c = fault | fault_clr;
    assign fault_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime: vector table plus multi-cycle corner sequences.
module tb_pwm_deadtime;

    localparam int unsigned DT_W = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            pwm_in;
    logic            en;
    logic [DT_W-1:0] dt_rise;
    logic [DT_W-1:0] dt_fall;
    logic            fault;
    logic            fault_clr;
    logic            pwm_h;
    logic            pwm_l;
    logic            fault_flag;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       pwm;
        logic       en;
        logic [7:0] dtr;
        logic [7:0] dtf;
        logic       eh;
        logic       el;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    pwm_deadtime #(
        .DT_W (DT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .en         (en),
        .dt_rise    (dt_rise),
        .dt_fall    (dt_fall),
        .fault      (fault),
        .fault_clr  (fault_clr),
        .pwm_h      (pwm_h),
        .pwm_l      (pwm_l),
        .fault_flag (fault_flag)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic eh, input logic el, input logic ef);
        check({name, ".pwm_h"}, 32'(pwm_h), 32'(eh));
        check({name, ".pwm_l"}, 32'(pwm_l), 32'(el));
        check({name, ".fault_flag"}, 32'(fault_flag), 32'(ef));
    endtask

    // Park in LOW with pwm_q low and no dead interval pending.
    task automatic settle_low();
        pwm_in = 1'b0;
        en     = 1'b1;
        for (int i = 0; i < 8; i++) step();
    endtask

    // Drive from LOW into HIGH using a one-cycle rise dead time.
    task automatic go_high();
        dt_rise = 8'd1;
        pwm_in  = 1'b1;
        step();
        step();
        step();
    endtask

    // Square wave, period 20; measures latency and dead band on every edge.
    task automatic run_square(input int dr, input int df, input int ncyc);
        int d_r, d_f;
        int last_q_rise, last_q_fall, last_l_fall, last_h_fall;
        int n_hr, n_lr;
        logic q, prev_q, prev_h, prev_l;
        d_r = (dr == 0) ? 1 : dr;
        d_f = (df == 0) ? 1 : df;
        dt_rise = DT_W'(dr);
        dt_fall = DT_W'(df);
        settle_low();
        prev_q = 1'b0;
        prev_h = pwm_h;
        prev_l = pwm_l;
        last_q_rise = -1000; last_q_fall = -1000;
        last_l_fall = -1000; last_h_fall = -1000;
        n_hr = 0; n_lr = 0;
        for (int i = 0; i < ncyc; i++) begin
            pwm_in = (((i / 10) % 2) == 1);
            step();
            q = pwm_in;
            if (q && !prev_q) last_q_rise = i;
            if (!q && prev_q) last_q_fall = i;
            if (!pwm_l && prev_l) last_l_fall = i;
            if (!pwm_h && prev_h) last_h_fall = i;
            if (pwm_h && !prev_h) begin
                n_hr++;
                check("sq_h_rise_latency", 32'(i - last_q_rise), 32'(d_r + 1));
                check("sq_dead_band_l_to_h", 32'(i - last_l_fall), 32'(d_r));
            end
            if (pwm_l && !prev_l) begin
                n_lr++;
                check("sq_l_rise_latency", 32'(i - last_q_fall), 32'(d_f + 1));
                check("sq_dead_band_h_to_l", 32'(i - last_h_fall), 32'(d_f));
            end
            prev_q = q;
            prev_h = pwm_h;
            prev_l = pwm_l;
        end
        check("sq_h_rise_count", 32'(n_hr), 32'd3);
        check("sq_l_rise_count", 32'(n_lr), 32'd3);
    endtask

    // Outputs must never overlap, in any cycle.
    always @(negedge clk) begin
        n_checks++;
        if (pwm_h && pwm_l) begin
            n_fail++;
            $display("FAIL overlap: pwm_h=%0b pwm_l=%0b, expected not both 1 (t=%0t)", pwm_h, pwm_l, $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_l[10];

        vecs[0]  = '{1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 8'd2, 8'd1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 8'd2, 8'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'd2, 8'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 8'd2, 8'd1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'd2, 8'd1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'd2, 8'd1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'd2, 8'd1, 1'b0, 1'b1};

        // Reset state
        reset = 1'b0; pwm_in = 1'b0; en = 1'b0;
        dt_rise = 8'd0; dt_fall = 8'd0; fault = 1'b0; fault_clr = 1'b0;
        step();
        step();
        check_out("reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Basic vector table: enable, rise/fall dead time, short pulse, disable
        for (int i = 0; i < 14; i++) begin
            pwm_in  = vecs[i].pwm;
            en      = vecs[i].en;
            dt_rise = vecs[i].dtr;
            dt_fall = vecs[i].dtf;
            step();
            check($sformatf("vec%0d.pwm_h", i), 32'(pwm_h), 32'(vecs[i].eh));
            check($sformatf("vec%0d.pwm_l", i), 32'(pwm_l), 32'(vecs[i].el));
        end

        // Square wave with dt_rise=3, dt_fall=5, then zero dead times
        run_square(3, 5, 70);
        run_square(0, 0, 70);

        // Two-cycle pulse swallowed by a six-cycle rise dead time
        dt_rise = 8'd6; dt_fall = 8'd1;
        settle_low();
        exp_l = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            pwm_in = (i < 2);
            step();
            check($sformatf("short%0d.pwm_h", i), 32'(pwm_h), 32'd0);
            check($sformatf("short%0d.pwm_l", i), 32'(pwm_l), 32'(exp_l[i]));
        end

        // Enable dropped while HIGH
        dt_fall = 8'd1;
        settle_low();
        go_high();
        check_out("en_drop.high", 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        step();
        check_out("en_drop.off", 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        step();
        check_out("en_drop.low", 1'b0, 1'b1, 1'b0);
        pwm_in = 1'b0;

        // Reset applied inside the fall dead interval with two cycles left
        dt_fall = 8'd5;
        settle_low();
        go_high();
        check_out("rst_dtf.high", 1'b1, 1'b0, 1'b0);
        pwm_in = 1'b0;
        step();
        check_out("rst_dtf.high_hold", 1'b1, 1'b0, 1'b0);
        step();
        check_out("rst_dtf.dt_f", 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        reset = 1'b0;
        step();
        check_out("rst_dtf.reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        en    = 1'b1;
        step();
        check_out("rst_dtf.off_to_low", 1'b0, 1'b1, 1'b0);

        // Trip handling
        dt_fall = 8'd1;
        settle_low();
        go_high();
        check_out("fault.high", 1'b1, 1'b0, 1'b0);
`ifdef PWM_DT_FAULT_EN
        fault = 1'b1;
        step();
        check_out("fault.trip", 1'b0, 1'b0, 1'b1);
        fault = 1'b0;
        step();
        check_out("fault.latched", 1'b0, 1'b0, 1'b1);
        fault = 1'b1; fault_clr = 1'b1;
        step();
        check_out("fault.clr_blocked", 1'b0, 1'b0, 1'b1);
        fault = 1'b0; fault_clr = 1'b1;
        step();
        check_out("fault.cleared_off", 1'b0, 1'b0, 1'b0);
        fault_clr = 1'b0;
        step();
        check_out("fault.relow", 1'b0, 1'b1, 1'b0);
`else
        fault = 1'b1;
        step();
        check_out("fault.ignored", 1'b1, 1'b0, 1'b0);
        fault_clr = 1'b1;
        step();
        check_out("fault.clr_ignored", 1'b1, 1'b0, 1'b0);
        fault = 1'b0; fault_clr = 1'b0;
`endif
        pwm_in = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter DT_W, default 8, the width of the dead-time count fields.
REQ-002 SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port pwm_in, input, 1 bit: the raw PWM from the upstream generator, same clk domain.
REQ-005 SHALL have port en, input, 1 bit: output-stage enable.
REQ-006 SHALL have port dt_rise, input, DT_W bits: dead cycles inserted before pwm_h asserts.
REQ-007 SHALL have port dt_fall, input, DT_W bits: dead cycles inserted before pwm_l asserts.
REQ-008 SHALL have port fault, input, 1 bit: external trip request.
REQ-009 SHALL have port fault_clr, input, 1 bit: clear request for a latched trip.
REQ-010 SHALL have port pwm_h, output, 1 bit: high-side gate drive.
REQ-011 SHALL have port pwm_l, output, 1 bit: low-side gate drive.
REQ-012 SHALL have port fault_flag, output, 1 bit: trip latched.

Function
REQ-013 SHALL register pwm_in once (pwm_q); the FSM acts only on pwm_q.
REQ-014 SHALL implement the states OFF, LOW, DT_R, HIGH, DT_F and FAULT, with all outputs registered and decoded from state.
REQ-015 SHALL drive the outputs per state: LOW gives pwm_l=1; HIGH gives pwm_h=1; every other state gives both outputs low.
REQ-016 SHALL transition as follows:
- OFF->LOW when en=1.
- LOW->DT_R when pwm_q=1.
- DT_R->HIGH when the dead count expires.
- HIGH->DT_F when pwm_q=0.
- DT_F->LOW when the dead count expires.
REQ-017 SHALL load the dead count with max(dt_rise,1) on entry to DT_R and with max(dt_fall,1) on entry to DT_F, then decrement it once per cycle.
- A programmed value of 0 SHALL behave as 1.
- Changes to dt_* mid-interval SHALL be ignored.
REQ-018 SHALL guarantee at least D cycles with both outputs low between any pwm_l fall and the following pwm_h rise, and likewise in the opposite direction.
REQ-019 SHALL meet this latency: with pwm_q first 1 at edge N, pwm_l falls at edge N+1 and pwm_h rises at edge N+1+D, where D=max(dt_rise,1). The falling direction SHALL be symmetric using dt_fall.
REQ-020 SHALL handle short pulses in the dead states:
- pwm_q=0 while in DT_R SHALL return to LOW at the next edge, so the pulse is swallowed and pwm_h never asserts.
- pwm_q=1 while in DT_F SHALL return to HIGH at the next edge.
REQ-021 SHALL move from any non-FAULT state to OFF at the next edge when en=0.
REQ-022 SHALL never assert pwm_h and pwm_l in the same cycle under any input sequence.

Reset
REQ-023 SHALL, when reset=0 at a clock edge, set the state to OFF, pwm_q=0, the dead count to 0, pwm_h=0, pwm_l=0 and fault_flag=0.
REQ-024 SHALL give reset priority over fault, en and every state, including a reset asserted mid-dead-interval.

Configuration
REQ-025 SHALL, when macro PWM_DT_FAULT_EN is defined, move to FAULT at the next edge on fault=1 from any state.
- fault_flag SHALL be 1 while in FAULT.
- FAULT SHALL exit to OFF only when fault_clr=1 and fault=0 in the same cycle.
- When fault and fault_clr are both 1, fault SHALL win.
REQ-026 SHALL, when PWM_DT_FAULT_EN is undefined, still have the fault and fault_clr ports but ignore them, exclude the FAULT state, and tie fault_flag to 0.

Structure
REQ-027 SHALL place the state enum typedef and the default DT_W constant in shared package pwm_pkg.
REQ-028 SHALL implement the dead-time down-counter (load, decrement, expire flag) as sub-module pwm_dt_counter.

Verification
REQ-029 SHALL include a bench scenario where dt_rise=3, dt_fall=5 and pwm_in is a 20-cycle square wave: pwm_h rises 4 edges after pwm_q rises, pwm_l rises 6 edges after pwm_q falls, and the outputs never overlap.
REQ-030 SHALL include a bench scenario where dt_rise=0: the dead band is exactly 1 cycle.
REQ-031 SHALL include a bench scenario where dt_rise=6 and pwm_in is a 2-cycle high pulse: pwm_h stays 0 and pwm_l returns to 1.
REQ-032 SHALL include a bench scenario where en is dropped while in HIGH: both outputs are 0 next edge; with en=1 again, LOW follows one edge later.
REQ-033 SHALL include a bench scenario, with PWM_DT_FAULT_EN defined, where fault is pulsed during HIGH: both outputs are 0 and fault_flag=1 next edge; fault_clr=1 with fault=1 has no effect; fault_clr=1 with fault=0 gives OFF.
REQ-034 SHALL include a bench scenario where reset=0 is applied in DT_F with the count at 2: all outputs are 0 next edge and the state is OFF.
